// File: rtl/multiword_add_seq.sv
// Word-serial wide adder: one shared s-bit fulladder slice, LSW first, with start/busy/done.
// Optional signed-overflow output o_ovf is built only when MWADD_OVF_EN is defined.

module fulladder #(
  parameter int unsigned s = 4
) (
  input  logic [s-1:0] i_a,
  input  logic [s-1:0] i_b,
  input  logic         i_cin,
  output logic [s-1:0] o_sum,
  output logic         o_cout
);

  always_comb begin
    {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{s{1'b0}}, i_cin};
  end

endmodule

module multiword_add_seq #(
  parameter int unsigned s     = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [s*WORDS-1:0] i_a,
  input  logic [s*WORDS-1:0] i_b,
  input  logic               i_cin,
  output logic               o_busy,
  output logic               o_done,
  output logic [s*WORDS-1:0] o_sum,
  output logic               o_cout
`ifdef MWADD_OVF_EN
  ,
  output logic               o_ovf
`endif
);

  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                     r_state, w_state_nxt;
  logic [WORDS-1:0][s-1:0]    r_a, w_a_nxt;
  logic [WORDS-1:0][s-1:0]    r_b, w_b_nxt;
  logic [WORDS-1:0][s-1:0]    r_sum, w_sum_nxt;
  logic                       r_carry, w_carry_nxt;
  logic [IdxW-1:0]            r_idx, w_idx_nxt;
  logic                       r_cout, w_cout_nxt;
`ifdef MWADD_OVF_EN
  logic                       r_ovf, w_ovf_nxt;
`endif

  logic [s-1:0]               w_add_sum;
  logic                       w_add_cout;
  logic                       w_accept;

  fulladder #(
    .s (s)
  ) u_slice (
    .i_a    (r_a[r_idx]),
    .i_b    (r_b[r_idx]),
    .i_cin  (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  // A start held through DONE is taken on the DONE->exit edge so that a continuous
  // request gets one add every WORDS+1 cycles; a start during RUN is always dropped.
  assign w_accept = i_start && ((r_state == StIdle) || (r_state == StDone));

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sum_nxt   = r_sum;
    w_carry_nxt = r_carry;
    w_idx_nxt   = r_idx;
    w_cout_nxt  = r_cout;
`ifdef MWADD_OVF_EN
    w_ovf_nxt   = r_ovf;
`endif

    unique case (r_state)
      StIdle: begin
        w_state_nxt = StIdle;
      end
      StRun: begin
        w_sum_nxt[r_idx] = w_add_sum;
        w_carry_nxt      = w_add_cout;
        if (r_idx == LastIdx) begin
          w_cout_nxt  = w_add_cout;
`ifdef MWADD_OVF_EN
          w_ovf_nxt   = (r_a[WORDS-1][s-1] == r_b[WORDS-1][s-1]) &&
                        (w_add_sum[s-1] != r_a[WORDS-1][s-1]);
`endif
          w_state_nxt = StDone;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (w_accept) begin
      w_a_nxt     = i_a;
      w_b_nxt     = i_b;
      w_carry_nxt = i_cin;
      w_idx_nxt   = '0;
      w_state_nxt = StRun;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
`ifdef MWADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_sum   <= w_sum_nxt;
      r_carry <= w_carry_nxt;
      r_idx   <= w_idx_nxt;
      r_cout  <= w_cout_nxt;
`ifdef MWADD_OVF_EN
      r_ovf   <= w_ovf_nxt;
`endif
    end
  end

  assign o_busy = (r_state != StIdle);
  assign o_done = (r_state == StDone);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
`ifdef MWADD_OVF_EN
  assign o_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (s=4, WORDS=4); ovf checks only under MWADD_OVF_EN.

module tb_multiword_add_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
`ifdef MWADD_OVF_EN
  logic        ovf;
`endif

  int n_total = 0;
  int n_bad   = 0;

  multiword_add_seq #(
    .s     (4),
    .WORDS (4)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout)
`ifdef MWADD_OVF_EN
    ,
    .o_ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one add and return the number of cycles from the accepting edge to done (-1 on timeout).
  task automatic run_add(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         output int lat);
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    cin   = vc;
    @(posedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
      end
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int done_cnt;
    int cyc;
    int dpos[3];

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'h005E, 16'h0017, 1'b0, 16'h0075, 1'b0, 1'b0};
    vecs[2] = '{16'h007E, 16'h001F, 1'b1, 16'h009E, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'hA1B2, 16'h5E4F, 1'b1, 16'h0002, 1'b1, 1'b0};

    // Reset with start asserted: the start must be dropped.
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    cin   = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_sum", {16'b0, sum}, 32'h0);
    check("reset_cout", {31'b0, cout}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_add(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("v%0d_latency", i), lat, 32'd4);
      check($sformatf("v%0d_sum", i), {16'b0, sum}, {16'b0, vecs[i].sum});
      check($sformatf("v%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].cout});
      check($sformatf("v%0d_busy_in_done", i), {31'b0, busy}, 32'd1);
`ifdef MWADD_OVF_EN
      check($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].ovf});
`endif
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
      check($sformatf("v%0d_idle", i), {31'b0, busy}, 32'd0);
      check($sformatf("v%0d_sum_hold", i), {16'b0, sum}, {16'b0, vecs[i].sum});
    end

    // start and operand changes during RUN are ignored.
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h1111;
    cin   = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (n == 1) begin
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
      end
      if (n == 2) begin
        start = 1'b0;
        a     = 16'hAAAA;
        b     = 16'h5555;
      end
      if (done) begin
        done_cnt++;
        check("busy_start_sum", {16'b0, sum}, 32'h2345);
        check("busy_start_cout", {31'b0, cout}, 32'd0);
      end
    end
    check("busy_start_done_count", done_cnt, 32'd1);
    check("busy_start_sum_held", {16'b0, sum}, 32'h2345);

    // start held high: one add every WORDS+1 cycles.
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    a     = 16'h0001;
    b     = 16'h0002;
    cin   = 1'b0;
    for (cyc = 0; cyc < 30 && done_cnt < 3; cyc++) begin
      @(negedge clk);
      if (done) begin
        dpos[done_cnt] = cyc;
        done_cnt++;
        check("b2b_sum", {16'b0, sum}, 32'h0003);
      end
    end
    start = 1'b0;
    check("b2b_done_count", done_cnt, 32'd3);
    if (done_cnt == 3) begin
      check("b2b_interval0", dpos[1] - dpos[0], 32'd5);
      check("b2b_interval1", dpos[2] - dpos[1], 32'd5);
    end
    repeat (8) @(negedge clk);
    check("b2b_drained", {31'b0, busy}, 32'd0);

    // Reset in the middle of RUN aborts the add.
    @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'h0001;
    cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_busy", {31'b0, busy}, 32'd0);
    check("midrun_rst_done", {31'b0, done}, 32'd0);
    check("midrun_rst_sum", {16'b0, sum}, 32'h0);
    check("midrun_rst_cout", {31'b0, cout}, 32'd0);
`ifdef MWADD_OVF_EN
    check("midrun_rst_ovf", {31'b0, ovf}, 32'd0);
`endif
    done_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrun_rst_no_done", done_cnt, 32'd0);
    run_add(16'h0003, 16'h0004, 1'b0, lat);
    check("post_rst_latency", lat, 32'd4);
    check("post_rst_sum", {16'b0, sum}, 32'h0007);
    check("post_rst_cout", {31'b0, cout}, 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
